id_ex_stage: RTL and testbench

ID/EX pipeline stage of the MIPS pipeline, directly upstream of the ALU. It registers decoded instruction fields and control bits from ID. After the register it applies operand forwarding from EX/MEM and MEM/WB. It drives the ALU's `a`, `b` and 4-bit `alu_control` inputs. It also supports stall (hold) and flush (bubble insertion) for the hazard logic.

---
 rtl/id_ex_stage_pkg.sv | 67 ++++++
 rtl/id_ex_stage_if.sv | 67 ++++++
 rtl/id_ex_stage_forward_unit.sv | 35 +++
 rtl/id_ex_stage.sv | 100 ++++++++++
 tb/tb_id_ex_stage.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/id_ex_stage_pkg.sv
// Shared MIPS pipeline definitions: ALU control codes, alu_op/funct encodings,
// the ID/EX register layout and the decode/sign-extend helpers.
package mips_pkg;

    localparam int W = 32;

    localparam logic [3:0] OP_ADD     = 4'b0010;
    localparam logic [3:0] OP_SUB     = 4'b0110;
    localparam logic [3:0] OP_ILLEGAL = 4'b1111;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_RTYPE = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_e;

    typedef struct packed {
        logic         valid;
        logic [W-1:0] rs_data;
        logic [W-1:0] rt_data;
        logic [W-1:0] imm_ext;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   write_reg;
        logic [3:0]   alu_ctrl;
        logic         alu_src;
        logic         reg_write;
        logic         mem_read;
        logic         mem_write;
        logic         branch;
        logic         illegal;
    } id_ex_reg_t;

    function automatic logic [3:0] alu_decode(input logic [1:0] alu_op, input logic [5:0] funct);
        logic [3:0] ctrl;
        case (alu_op_e'(alu_op))
            ALUOP_ADD: ctrl = OP_ADD;
            ALUOP_SUB: ctrl = OP_SUB;
            ALUOP_RTYPE: begin
                case (funct)
                    FUNCT_ADD: ctrl = OP_ADD;
                    FUNCT_SUB: ctrl = OP_SUB;
                    default:   ctrl = OP_ILLEGAL;
                endcase
            end
            default: ctrl = OP_ILLEGAL;
        endcase
        return ctrl;
    endfunction

    function automatic logic [W-1:0] sign_extend16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

    // A bubble decodes as a harmless add with nothing enabled.
    function automatic id_ex_reg_t bubble_entry();
        id_ex_reg_t b;
        b           = '0;
        b.alu_ctrl  = OP_ADD;
        return b;
    endfunction

endpackage

// File: rtl/id_ex_stage_if.sv
// Bundle of ID-side inputs, forwarding sources and EX-side outputs of the
// ID/EX stage; master drives the stage, slave is the stage itself.
interface id_ex_if;
    import mips_pkg::*;

    logic         stall;
    logic         flush;
    logic         id_valid;
    logic [W-1:0] id_rs_data;
    logic [W-1:0] id_rt_data;
    logic [15:0]  id_imm16;
    logic [4:0]   id_rs;
    logic [4:0]   id_rt;
    logic [4:0]   id_rd;
    logic [1:0]   id_alu_op;
    logic [5:0]   id_funct;
    logic         id_alu_src;
    logic         id_reg_dst;
    logic         id_reg_write;
    logic         id_mem_read;
    logic         id_mem_write;
    logic         id_branch;

    logic         exmem_reg_write;
    logic [4:0]   exmem_rd;
    logic [W-1:0] exmem_result;
    logic         memwb_reg_write;
    logic [4:0]   memwb_rd;
    logic [W-1:0] memwb_result;

    logic         ex_valid;
    logic [W-1:0] alu_a;
    logic [W-1:0] alu_b;
    logic [3:0]   alu_control;
    logic [W-1:0] ex_store_data;
    logic [4:0]   ex_write_reg;
    logic         ex_reg_write;
    logic         ex_mem_read;
    logic         ex_mem_write;
    logic         ex_branch;
    logic         ex_illegal;
    logic [4:0]   ex_rs;
    logic [4:0]   ex_rt;

    modport master (
        output stall, flush, id_valid, id_rs_data, id_rt_data, id_imm16,
               id_rs, id_rt, id_rd, id_alu_op, id_funct, id_alu_src, id_reg_dst,
               id_reg_write, id_mem_read, id_mem_write, id_branch,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        input  ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal,
               ex_rs, ex_rt
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_data, id_rt_data, id_imm16,
               id_rs, id_rt, id_rd, id_alu_op, id_funct, id_alu_src, id_reg_dst,
               id_reg_write, id_mem_read, id_mem_write, id_branch,
               exmem_reg_write, exmem_rd, exmem_result,
               memwb_reg_write, memwb_rd, memwb_result,
        output ex_valid, alu_a, alu_b, alu_control, ex_store_data, ex_write_reg,
               ex_reg_write, ex_mem_read, ex_mem_write, ex_branch, ex_illegal,
               ex_rs, ex_rt
    );

endinterface

// File: rtl/id_ex_stage_forward_unit.sv
// Two-source operand forwarding mux: EX/MEM beats MEM/WB beats the register
// file value; register 0 is never forwarded.
module forward_unit
    import mips_pkg::*;
(
    input  logic [4:0]   spec_i,
    input  logic [W-1:0] regfile_i,
    input  logic         exmem_reg_write_i,
    input  logic [4:0]   exmem_rd_i,
    input  logic [W-1:0] exmem_result_i,
    input  logic         memwb_reg_write_i,
    input  logic [4:0]   memwb_rd_i,
    input  logic [W-1:0] memwb_result_i,
    output logic [W-1:0] data_o
);

    logic exmem_hit_s;
    logic memwb_hit_s;

    assign exmem_hit_s = exmem_reg_write_i && (exmem_rd_i != 5'd0) && (exmem_rd_i == spec_i);
    assign memwb_hit_s = memwb_reg_write_i && (memwb_rd_i != 5'd0) && (memwb_rd_i == spec_i);

    // Priority selection of the operand source.
    always_comb begin
        data_o = regfile_i;
        if (exmem_hit_s) begin
            data_o = exmem_result_i;
        end else if (memwb_hit_s) begin
            data_o = memwb_result_i;
        end else begin
            data_o = regfile_i;
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with ALU-control decode and sign-extension ahead of
// the register, and operand forwarding after it.
module id_ex_stage
    import mips_pkg::*;
(
    input  logic clk,
    input  logic reset,
    id_ex_if.slave bus
);

    id_ex_reg_t   stage_q;
    id_ex_reg_t   stage_d;
    id_ex_reg_t   capture_s;
    logic [3:0]   alu_ctrl_s;
    logic         illegal_s;
    logic [W-1:0] fwd_rs_s;
    logic [W-1:0] fwd_rt_s;

    // Decode the incoming ID fields into the shape held by the register.
    always_comb begin
        alu_ctrl_s          = alu_decode(bus.id_alu_op, bus.id_funct);
        illegal_s           = (alu_ctrl_s == OP_ILLEGAL);
        capture_s           = '0;
        capture_s.valid     = bus.id_valid;
        capture_s.rs_data   = bus.id_rs_data;
        capture_s.rt_data   = bus.id_rt_data;
        capture_s.imm_ext   = sign_extend16(bus.id_imm16);
        capture_s.rs        = bus.id_rs;
        capture_s.rt        = bus.id_rt;
        capture_s.write_reg = bus.id_reg_dst ? bus.id_rd : bus.id_rt;
        capture_s.alu_ctrl  = alu_ctrl_s;
        capture_s.alu_src   = bus.id_alu_src;
        // An unsupported operation must not update any architectural state.
        capture_s.reg_write = bus.id_reg_write & ~illegal_s;
        capture_s.mem_read  = bus.id_mem_read  & ~illegal_s;
        capture_s.mem_write = bus.id_mem_write & ~illegal_s;
        capture_s.branch    = bus.id_branch;
        capture_s.illegal   = illegal_s;
    end

    // Next-state selection: flush over stall over capture.
    always_comb begin
        stage_d = stage_q;
        if (bus.flush) begin
            stage_d = bubble_entry();
        end else if (bus.stall) begin
            stage_d = stage_q;
        end else begin
            stage_d = capture_s;
        end
    end

    // Pipeline register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stage_q <= bubble_entry();
        end else begin
            stage_q <= stage_d;
        end
    end

    forward_unit u_fwd_rs (
        .spec_i            (stage_q.rs),
        .regfile_i         (stage_q.rs_data),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .exmem_rd_i        (bus.exmem_rd),
        .exmem_result_i    (bus.exmem_result),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .memwb_rd_i        (bus.memwb_rd),
        .memwb_result_i    (bus.memwb_result),
        .data_o            (fwd_rs_s)
    );

    forward_unit u_fwd_rt (
        .spec_i            (stage_q.rt),
        .regfile_i         (stage_q.rt_data),
        .exmem_reg_write_i (bus.exmem_reg_write),
        .exmem_rd_i        (bus.exmem_rd),
        .exmem_result_i    (bus.exmem_result),
        .memwb_reg_write_i (bus.memwb_reg_write),
        .memwb_rd_i        (bus.memwb_rd),
        .memwb_result_i    (bus.memwb_result),
        .data_o            (fwd_rt_s)
    );

    assign bus.alu_a         = fwd_rs_s;
    assign bus.alu_b         = stage_q.alu_src ? stage_q.imm_ext : fwd_rt_s;
    assign bus.ex_store_data = fwd_rt_s;
    assign bus.ex_valid      = stage_q.valid;
    assign bus.alu_control   = stage_q.alu_ctrl;
    assign bus.ex_write_reg  = stage_q.write_reg;
    assign bus.ex_reg_write  = stage_q.reg_write;
    assign bus.ex_mem_read   = stage_q.mem_read;
    assign bus.ex_mem_write  = stage_q.mem_write;
    assign bus.ex_branch     = stage_q.branch;
    assign bus.ex_illegal    = stage_q.illegal;
    assign bus.ex_rs         = stage_q.rs;
    assign bus.ex_rt         = stage_q.rt;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: directed vectors push hand-computed
// expectations, an independent monitor pops and compares them.
module tb_id_ex_stage;

    logic clk;
    logic reset;

    id_ex_if bus ();

    id_ex_stage dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] store;
        logic [3:0]  ctrl;
        logic [4:0]  wreg;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        br;
        logic        ill;
    } exp_t;

    exp_t q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_ev;

    function automatic exp_t mk(input string nm, input logic v, input logic [31:0] a,
                                input logic [31:0] b, input logic [31:0] st, input logic [3:0] c,
                                input logic [4:0] wr, input logic [4:0] rs, input logic [4:0] rt,
                                input logic rw, input logic mr, input logic mw, input logic br,
                                input logic ill);
        exp_t e;
        e.name = nm; e.valid = v; e.a = a; e.b = b; e.store = st; e.ctrl = c;
        e.wreg = wr; e.rs = rs; e.rt = rt; e.rw = rw; e.mr = mr; e.mw = mw;
        e.br = br; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t bubble(input string nm);
        return mk(nm, 1'b0, 32'd0, 32'd0, 32'd0, 4'b0010, 5'd0, 5'd0, 5'd0,
                  1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endfunction

    task automatic chk(input string nm, input string fld, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s.%s actual=%h expected=%h", nm, fld, act, exp);
        end
    endtask

    // Monitor: compare every pending expectation at the sampling point.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk or sample_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "ex_valid",      {31'd0, bus.ex_valid},     {31'd0, e.valid});
                chk(e.name, "alu_a",         bus.alu_a,                 e.a);
                chk(e.name, "alu_b",         bus.alu_b,                 e.b);
                chk(e.name, "ex_store_data", bus.ex_store_data,         e.store);
                chk(e.name, "alu_control",   {28'd0, bus.alu_control},  {28'd0, e.ctrl});
                chk(e.name, "ex_write_reg",  {27'd0, bus.ex_write_reg}, {27'd0, e.wreg});
                chk(e.name, "ex_rs",         {27'd0, bus.ex_rs},        {27'd0, e.rs});
                chk(e.name, "ex_rt",         {27'd0, bus.ex_rt},        {27'd0, e.rt});
                chk(e.name, "ex_reg_write",  {31'd0, bus.ex_reg_write}, {31'd0, e.rw});
                chk(e.name, "ex_mem_read",   {31'd0, bus.ex_mem_read},  {31'd0, e.mr});
                chk(e.name, "ex_mem_write",  {31'd0, bus.ex_mem_write}, {31'd0, e.mw});
                chk(e.name, "ex_branch",     {31'd0, bus.ex_branch},    {31'd0, e.br});
                chk(e.name, "ex_illegal",    {31'd0, bus.ex_illegal},   {31'd0, e.ill});
            end
        end
    end

    task automatic set_id(input logic v, input logic [1:0] op, input logic [5:0] fn,
                          input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                          input logic [31:0] rsd, input logic [31:0] rtd, input logic [15:0] imm,
                          input logic src, input logic dst, input logic rw, input logic mr,
                          input logic mw, input logic br);
        bus.id_valid = v; bus.id_alu_op = op; bus.id_funct = fn;
        bus.id_rs = rs; bus.id_rt = rt; bus.id_rd = rd;
        bus.id_rs_data = rsd; bus.id_rt_data = rtd; bus.id_imm16 = imm;
        bus.id_alu_src = src; bus.id_reg_dst = dst; bus.id_reg_write = rw;
        bus.id_mem_read = mr; bus.id_mem_write = mw; bus.id_branch = br;
    endtask

    task automatic set_fwd(input logic erw, input logic [4:0] erd, input logic [31:0] eres,
                           input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        bus.exmem_reg_write = erw; bus.exmem_rd = erd; bus.exmem_result = eres;
        bus.memwb_reg_write = wrw; bus.memwb_rd = wrd; bus.memwb_result = wres;
    endtask

    // Cross one rising edge, then have the monitor check at the next falling edge.
    task automatic step(input exp_t e);
        @(posedge clk);
        #1;
        q.push_back(e);
        @(negedge clk);
        #1;
    endtask

    // Check immediately, without crossing any clock edge.
    task automatic settle(input exp_t e);
        #1;
        q.push_back(e);
        ->sample_ev;
        #1;
    endtask

    initial begin
        reset = 1'b1;
        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_id(1'b0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 16'd0,
               1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        #1;
        settle(bubble("reset_initial"));
        @(negedge clk);
        #1;
        reset = 1'b0;

        set_id(1'b1, 2'b10, 6'b100010, 5'd1, 5'd2, 5'd9, 32'd7, 32'd3, 16'h0000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk("rtype_sub", 1'b1, 32'd7, 32'd3, 32'd3, 4'b0110, 5'd9, 5'd1, 5'd2,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        set_id(1'b1, 2'b00, 6'd0, 5'd3, 5'd4, 5'd0, 32'd100, 32'd55, 16'hFFFC,
               1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        step(mk("lw_imm", 1'b1, 32'd100, 32'hFFFF_FFFC, 32'd55, 4'b0010, 5'd4, 5'd3, 5'd4,
                1'b1, 1'b1, 1'b0, 1'b0, 1'b0));

        set_id(1'b1, 2'b10, 6'b100000, 5'd5, 5'd6, 5'd7, 32'd1, 32'd2, 16'h0000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd5, 32'd11, 1'b1, 5'd5, 32'd22);
        step(mk("fwd_exmem_first", 1'b1, 32'd11, 32'd2, 32'd2, 4'b0010, 5'd7, 5'd5, 5'd6,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        bus.stall = 1'b1;
        set_id(1'b1, 2'b01, 6'd0, 5'd8, 5'd8, 5'd8, 32'd999, 32'd999, 16'h1234,
               1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1);
        set_fwd(1'b0, 5'd5, 32'd11, 1'b1, 5'd5, 32'd22);
        step(mk("stall_fwd_memwb", 1'b1, 32'd22, 32'd2, 32'd2, 4'b0010, 5'd7, 5'd5, 5'd6,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        set_fwd(1'b0, 5'd5, 32'd11, 1'b1, 5'd6, 32'd22);
        step(mk("stall2_fwd_rt", 1'b1, 32'd1, 32'd22, 32'd22, 4'b0010, 5'd7, 5'd5, 5'd6,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        set_fwd(1'b1, 5'd6, 32'd33, 1'b1, 5'd6, 32'd22);
        settle(mk("stall_refwd_exmem", 1'b1, 32'd1, 32'd33, 32'd33, 4'b0010, 5'd7, 5'd5, 5'd6,
                  1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        bus.stall = 1'b0;
        set_id(1'b1, 2'b00, 6'd0, 5'd0, 5'd0, 5'd3, 32'd44, 32'd45, 16'h0000,
               1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b1, 5'd0, 32'd11, 1'b1, 5'd0, 32'd22);
        step(mk("r0_not_forwarded", 1'b1, 32'd44, 32'd45, 32'd45, 4'b0010, 5'd0, 5'd0, 5'd0,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        bus.stall = 1'b1;
        bus.flush = 1'b1;
        step(bubble("stall_and_flush"));

        bus.stall = 1'b0;
        bus.flush = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        set_id(1'b1, 2'b10, 6'b100100, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 16'h0000,
               1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(mk("illegal_funct", 1'b1, 32'd5, 32'd6, 32'd6, 4'b1111, 5'd3, 5'd1, 5'd2,
                1'b0, 1'b0, 1'b0, 1'b1, 1'b1));

        set_id(1'b1, 2'b11, 6'b100000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 16'h0000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(mk("illegal_aluop", 1'b1, 32'd5, 32'd6, 32'd6, 4'b1111, 5'd3, 5'd1, 5'd2,
                1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

        set_id(1'b1, 2'b01, 6'd0, 5'd10, 5'd11, 5'd0, 32'd50, 32'd77, 16'h7FFF,
               1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(mk("sub_imm_store", 1'b1, 32'd50, 32'h0000_7FFF, 32'd77, 4'b0110, 5'd11, 5'd10, 5'd11,
                1'b0, 1'b0, 1'b1, 1'b0, 1'b0));

        bus.stall = 1'b1;
        reset = 1'b1;
        settle(bubble("reset_async_mid_stall"));

        bus.stall = 1'b0;
        set_id(1'b1, 2'b10, 6'b100010, 5'd1, 5'd2, 5'd9, 32'd7, 32'd3, 16'h0000,
               1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        step(bubble("reset_held"));

        reset = 1'b0;
        step(mk("after_reset", 1'b1, 32'd7, 32'd3, 32'd3, 4'b0110, 5'd9, 5'd1, 5'd2,
                1'b1, 1'b0, 1'b0, 1'b0, 1'b0));

        bus.flush = 1'b1;
        step(bubble("flush_only"));
        bus.flush = 1'b0;

        @(negedge clk);
        #1;
        chk("scoreboard", "pending", q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
